// File: rtl/sram_seq_pkg.sv
// Shared sizes, step constants and types for the SRAM bank sequencer.
package sram_seq_pkg;
    localparam int NPH = 10;
    localparam int AW  = 5;
    localparam int DW  = 16;

    localparam int S_ADDR = 2;
    localparam int S_DATA = 4;
    localparam int S_CTL  = 6;
    localparam int S_WEN  = 8;
    localparam int S_LAST = 19;

    typedef enum logic { OP_READ, OP_WRITE } op_e;
    typedef enum logic { IDLE, RUN } state_e;

    function automatic logic in_win(input int s, input int lo, input int hi);
        return (s >= lo) && (s <= hi);
    endfunction
endpackage

// File: rtl/sram_phase_gen.sv
// Step counter and square Bennett phase vector; start loads step 0, last flags the final step.
module sram_phase_gen #(
    parameter int NPH = sram_seq_pkg::NPH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [NPH-1:0]           clkpos,
    output logic [$clog2(2*NPH)-1:0] step_nxt,
    output logic                     last
);
    import sram_seq_pkg::*;

    localparam int            SW       = $clog2(2*NPH);
    localparam logic [SW-1:0] STEP_MAX = SW'(2*NPH-1);

    logic           run;
    logic           run_n;
    logic [SW-1:0]  step;
    logic [NPH-1:0] clkpos_n;

    assign last = run && (step == STEP_MAX);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        run_n    = run;
        step_nxt = step;
        if (start) begin
            run_n    = 1'b1;
            step_nxt = '0;
        end else if (last) begin
            run_n    = 1'b0;
            step_nxt = '0;
        end else if (run) begin
            step_nxt = step + SW'(1);
        end
        // bit k is high over the symmetric window [k, 2*NPH-1-k]
        clkpos_n = '0;
        for (int k = 0; k < NPH; k++)
            clkpos_n[k] = run_n && in_win(int'(step_nxt), k, 2*NPH-1-k);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            run    <= 1'b0;
            step   <= '0;
            clkpos <= '0;
        end else begin
            run    <= run_n;
            step   <= step_nxt;
            clkpos <= clkpos_n;
        end
    end
endmodule

// File: rtl/sram_bank_sequencer.sv
// Drives one 2-port SRAM bank operation per 20-step Bennett cycle; reads return a one-cycle response.
module sram_bank_sequencer #(
    parameter int NPH = sram_seq_pkg::NPH,
    parameter int AW  = sram_seq_pkg::AW,
    parameter int DW  = sram_seq_pkg::DW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [AW-1:0]  req_addr_a,
    input  logic [AW-1:0]  req_addr_b,
    input  logic [DW-1:0]  req_data,
    output logic           rsp_valid,
    output logic [DW-1:0]  rsp_a,
    output logic [DW-1:0]  rsp_b,
    output logic [NPH-1:0] clkpos,
    output logic [AW-1:0]  addr_a,
    output logic [AW-1:0]  addr_b,
    output logic [DW-1:0]  wdata,
    output logic           read_en,
    output logic           reg_wrt_bar,
    output logic           write_en,
    input  logic [DW-1:0]  bank_out_a,
    input  logic [DW-1:0]  bank_out_b
);
    import sram_seq_pkg::*;

    state_e                   state, state_n;
    op_e                      op_q, op_n;
    logic [AW-1:0]            lat_addr_a, lat_addr_b, addr_a_n, addr_b_n;
    logic [DW-1:0]            lat_data, data_n;
    logic                     accept, last, run_n, wr_n, rd_done;
    logic [$clog2(2*NPH)-1:0] step_nxt;
    int                       s_n;

    assign accept  = req_valid && req_ready;
    assign rd_done = last && (op_q == OP_READ);

    sram_phase_gen #(.NPH(NPH)) u_phase (
        .clk      (clk),
        .reset    (reset),
        .start    (accept),
        .clkpos   (clkpos),
        .step_nxt (step_nxt),
        .last     (last)
    );

    always_comb begin
        state_n  = state;
        op_n     = op_q;
        addr_a_n = lat_addr_a;
        addr_b_n = lat_addr_b;
        data_n   = lat_data;
        if (accept) begin
            state_n  = RUN;
            op_n     = op_e'(req_write);
            addr_a_n = req_addr_a;
            addr_b_n = req_addr_b;
            data_n   = req_data;
        end else if (last) begin
            state_n = IDLE;
        end
        run_n = (state_n == RUN);
        wr_n  = (op_n == OP_WRITE);
        s_n   = int'(step_nxt);
    end

    // Controls are registered from the next step so they line up with the registered phase vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= OP_READ;
            lat_addr_a  <= '0;
            lat_addr_b  <= '0;
            lat_data    <= '0;
            req_ready   <= 1'b1;
            addr_a      <= '0;
            addr_b      <= '0;
            wdata       <= '0;
            read_en     <= 1'b0;
            reg_wrt_bar <= 1'b0;
            write_en    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_a       <= '0;
            rsp_b       <= '0;
        end else begin
            state       <= state_n;
            op_q        <= op_n;
            lat_addr_a  <= addr_a_n;
            lat_addr_b  <= addr_b_n;
            lat_data    <= data_n;
            req_ready   <= !run_n || (s_n == S_LAST);
            addr_a      <= (run_n && in_win(s_n, S_ADDR, S_LAST - S_ADDR)) ? addr_a_n : '0;
            addr_b      <= (run_n && in_win(s_n, S_ADDR, S_LAST - S_ADDR)) ? addr_b_n : '0;
            wdata       <= (run_n && wr_n && in_win(s_n, S_DATA, S_LAST - S_DATA)) ? data_n : '0;
            reg_wrt_bar <= run_n && wr_n && in_win(s_n, S_CTL, S_LAST - S_CTL);
            read_en     <= run_n && !wr_n && in_win(s_n, S_CTL, S_CTL + 1);
            write_en    <= run_n && wr_n && (s_n == S_WEN);
            rsp_valid   <= rd_done;
            if (rd_done) begin
                rsp_a <= bank_out_a;
                rsp_b <= bank_out_b;
            end
        end
    end
endmodule

// File: tb/tb_sram_bank_sequencer.sv
// Directed bench: elapsed-step reference model with per-cycle compare, a simple bank model, literal spot checks.
module tb_sram_bank_sequencer;
    localparam int NPH   = 10;
    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int NSTEP = 2 * NPH;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid, req_ready, req_write;
    logic [AW-1:0]  req_addr_a, req_addr_b;
    logic [DW-1:0]  req_data;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_a, rsp_b;
    logic [NPH-1:0] clkpos;
    logic [AW-1:0]  addr_a, addr_b;
    logic [DW-1:0]  wdata;
    logic           read_en, reg_wrt_bar, write_en;
    logic [DW-1:0]  bank_out_a, bank_out_b;

    always #5 clk = ~clk;

    sram_bank_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr_a  (req_addr_a),
        .req_addr_b  (req_addr_b),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_a       (rsp_a),
        .rsp_b       (rsp_b),
        .clkpos      (clkpos),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .wdata       (wdata),
        .read_en     (read_en),
        .reg_wrt_bar (reg_wrt_bar),
        .write_en    (write_en),
        .bank_out_a  (bank_out_a),
        .bank_out_b  (bank_out_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int rsp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h, want %0h", name, cyc + 1, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] preload(input int i);
        return (i == 1) ? '0 : DW'(32'h1000 + i);
    endfunction

    // Bank model: writes on write_en, latches both read ports on read_en.
    logic [DW-1:0] bank_mem [32];
    logic          bank_loaded = 1'b0;
    always @(posedge clk) begin
        if (!bank_loaded) begin
            for (int i = 0; i < 32; i++) bank_mem[i] <= preload(i);
            bank_loaded <= 1'b1;
        end else begin
            if (write_en) bank_mem[addr_a] <= wdata;
            if (read_en) begin
                bank_out_a <= bank_mem[addr_a];
                bank_out_b <= bank_mem[addr_b];
            end
        end
    end

    // Reference model: an accepted request runs steps 0..19, one per cycle.
    logic          m_ok = 1'b0, m_loaded = 1'b0;
    logic          m_busy, m_wr, m_rv, m_ready;
    int            m_s;
    logic [AW-1:0] m_aa, m_ab;
    logic [DW-1:0] m_d, m_ra, m_rb;
    logic [DW-1:0] ref_mem [32];

    always @(posedge clk) begin
        cyc++;
        if (!m_loaded) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = preload(i);
            m_loaded = 1'b1;
        end
        if (reset) begin
            m_ok = 1'b1; m_busy = 1'b0; m_s = 0; m_rv = 1'b0;
            m_ra = '0; m_rb = '0; m_wr = 1'b0; m_aa = '0; m_ab = '0; m_d = '0;
        end else begin
            m_rv    = 1'b0;
            m_ready = !m_busy || (m_s == NSTEP - 1);
            if (m_busy && m_s == NSTEP - 1 && !m_wr) begin
                m_rv = 1'b1; m_ra = ref_mem[m_aa]; m_rb = ref_mem[m_ab];
            end
            if (m_busy) begin
                m_s++;
                if (m_s == NSTEP) m_busy = 1'b0;
            end
            if (req_valid && m_ready) begin
                m_busy = 1'b1; m_s = 0; m_wr = req_write;
                m_aa = req_addr_a; m_ab = req_addr_b; m_d = req_data;
                if (req_write) ref_mem[req_addr_a] = req_data;
            end
        end
    end

    logic [NPH-1:0] e_clk;
    logic           e_addr_win, e_data_win;
    always @(negedge clk) begin
        if (m_ok) begin
            for (int k = 0; k < NPH; k++)
                e_clk[k] = m_busy && (k <= m_s) && (m_s <= NSTEP - 1 - k);
            e_addr_win = m_busy && (m_s >= 2) && (m_s <= 17);
            e_data_win = m_busy && m_wr && (m_s >= 4) && (m_s <= 15);
            check("clkpos",      32'(clkpos),      32'(e_clk));
            check("req_ready",   32'(req_ready),   32'(!m_busy || m_s == NSTEP - 1));
            check("addr_a",      32'(addr_a),      e_addr_win ? 32'(m_aa) : 32'h0);
            check("addr_b",      32'(addr_b),      e_addr_win ? 32'(m_ab) : 32'h0);
            check("wdata",       32'(wdata),       e_data_win ? 32'(m_d) : 32'h0);
            check("reg_wrt_bar", 32'(reg_wrt_bar), 32'(m_busy && m_wr && m_s >= 6 && m_s <= 13));
            check("read_en",     32'(read_en),     32'(m_busy && !m_wr && m_s >= 6 && m_s <= 7));
            check("write_en",    32'(write_en),    32'(m_busy && m_wr && m_s == 8));
            check("rsp_valid",   32'(rsp_valid),   32'(m_rv));
            check("rsp_a",       32'(rsp_a),       32'(m_ra));
            check("rsp_b",       32'(rsp_b),       32'(m_rb));
            if (rsp_valid === 1'b1) rsp_q.push_back(cyc + 1);
        end
    end

    // acc is the accept edge T; the cycle after it is T+1.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] d, input bit hold, output int acc);
        logic rdy;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr_a = a; req_addr_b = b; req_data = d;
        acc = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy) acc = cyc;
        end
        if (acc < 0) check("accept_timeout", 32'h0, 32'h1);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic at(input int acc, input int n);
        do @(negedge clk); while (cyc + 1 < acc + n);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t, t1, t2, n0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr_a = '0; req_addr_b = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_clkpos", 32'(clkpos), 32'h0);
        check("rst_ready",  32'(req_ready), 32'h1);
        check("rst_rsp",    32'(rsp_valid), 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_clkpos", 32'(clkpos), 32'h0);
        end

        // write 16'hAAAA to address 4
        issue(1'b1, 5'd4, 5'd4, 16'hAAAA, 1'b0, t);
        at(t, 1);  check("w_clk_t1",  32'(clkpos), 32'h001);
        at(t, 2);  check("w_addr_t2", 32'(addr_a), 32'h0);
        at(t, 3);  check("w_addr_t3", 32'(addr_a), 32'h4);
                   check("w_clk_t3",  32'(clkpos), 32'h007);
        at(t, 4);  check("w_wd_t4",   32'(wdata),  32'h0);
        at(t, 5);  check("w_wd_t5",   32'(wdata),  32'hAAAA);
        at(t, 7);  check("w_rwb_t7",  32'(reg_wrt_bar), 32'h1);
        at(t, 9);  check("w_wen_t9",  32'(write_en), 32'h1);
                   check("w_clk_t9",  32'(clkpos), 32'h1FF);
        at(t, 10); check("w_wen_t10", 32'(write_en), 32'h0);
                   check("w_clk_t10", 32'(clkpos), 32'h3FF);
        at(t, 12); check("w_clk_t12", 32'(clkpos), 32'h1FF);
        at(t, 18); check("w_addr_t18", 32'(addr_b), 32'h4);
        at(t, 19); check("w_addr_t19", 32'(addr_b), 32'h0);
        at(t, 20); check("w_clk_t20", 32'(clkpos), 32'h001);
                   check("w_rdy_t20", 32'(req_ready), 32'h1);
        at(t, 21); check("w_clk_t21", 32'(clkpos), 32'h0);
                   check("w_norsp",   32'(rsp_valid), 32'h0);

        // read back: address 1 preloaded with 0, address 4 just written
        issue(1'b0, 5'd1, 5'd4, 16'h0, 1'b0, t);
        at(t, 6);  check("r_ren_t6",  32'(read_en), 32'h0);
        at(t, 7);  check("r_ren_t7",  32'(read_en), 32'h1);
        at(t, 8);  check("r_ren_t8",  32'(read_en), 32'h1);
        at(t, 9);  check("r_ren_t9",  32'(read_en), 32'h0);
        at(t, 21); check("r_rv_t21",  32'(rsp_valid), 32'h1);
                   check("r_a_t21",   32'(rsp_a), 32'h0);
                   check("r_b_t21",   32'(rsp_b), 32'hAAAA);
        at(t, 22); check("r_rv_t22",  32'(rsp_valid), 32'h0);
                   check("r_hold",    32'(rsp_b), 32'hAAAA);

        // back-to-back reads with req_valid held
        n0 = rsp_q.size();
        issue(1'b0, 5'd4, 5'd1, 16'h0, 1'b1, t1);
        issue(1'b0, 5'd0, 5'd4, 16'h0, 1'b0, t2);
        check("b2b_accept_gap", 32'(t2 - t1), 32'd20);
        at(t1, 21); check("b2b_clk_s0", 32'(clkpos), 32'h001);
                    check("b2b_rsp1_a", 32'(rsp_a), 32'hAAAA);
        at(t2, 21); check("b2b_rsp2_a", 32'(rsp_a), 32'h1000);
                    check("b2b_rsp2_b", 32'(rsp_b), 32'hAAAA);
        at(t2, 22);
        check("b2b_rsp_count", 32'(rsp_q.size()), 32'(n0 + 2));
        if (rsp_q.size() >= n0 + 2)
            check("b2b_rsp_gap", 32'(rsp_q[n0 + 1] - rsp_q[n0]), 32'd20);

        // busy ignore: request pulsed during s = 5 of a write
        issue(1'b1, 5'd5, 5'd5, 16'h1234, 1'b0, t);
        at(t, 5);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr_a = 5'd7; req_addr_b = 5'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        at(t, 9);  check("bi_wen",  32'(write_en), 32'h1);
                   check("bi_addr", 32'(addr_a), 32'h5);
                   check("bi_wd",   32'(wdata), 32'h1234);
        at(t, 21); check("bi_norsp", 32'(rsp_valid), 32'h0);
                   check("bi_rdy",   32'(req_ready), 32'h1);

        // reset during s = 9 of a write, with a request offered in the same cycle
        issue(1'b1, 5'd6, 5'd6, 16'hBEEF, 1'b0, t);
        at(t, 9);
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("rs_clkpos", 32'(clkpos), 32'h0);
        check("rs_ready",  32'(req_ready), 32'h1);
        check("rs_addr",   32'(addr_a), 32'h0);
        @(negedge clk);
        check("rs_noacc",  32'(clkpos), 32'h0);

        n0 = rsp_q.size();
        issue(1'b0, 5'd6, 5'd5, 16'h0, 1'b0, t);
        at(t, 21); check("rs_rv",  32'(rsp_valid), 32'h1);
                   check("rs_a",   32'(rsp_a), 32'hBEEF);
                   check("rs_b",   32'(rsp_b), 32'h1234);
        at(t, 22);
        check("rs_rsp_count", 32'(rsp_q.size()), 32'(n0 + 1));
        if (rsp_q.size() > n0)
            check("rs_latency", 32'(rsp_q[n0] - t), 32'd21);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
